// File: rtl/adpcm_log_seq.sv
// rtl/adpcm_log_seq.sv - G.726 linear-to-log converter with a one-bit-per-clock shift normalizer
`timescale 1ns/1ps

module adpcm_log_seq (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] D,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic [10:0] DL,
  output logic        DS,
  output logic        OUT_VALID,
  input  logic        OUT_READY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [14:0] sr;
  logic [3:0]  expo;
  logic        sign;
  logic [14:0] d_neg;
  logic [14:0] dqm;
  logic        norm_done;

  // Only the low 15 bits of the negation matter, so 0x8000 folds to a zero
  // magnitude exactly as the reference converter does.
  assign d_neg     = 15'd0 - D[14:0];
  assign dqm       = D[15] ? d_neg : D[14:0];

  // Zero exponent wins over shifting so small or zero magnitudes terminate.
  assign norm_done = sr[14] | (expo == 4'd0);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (IN_VALID)  state_nxt = NORM;
      NORM:    if (norm_done) state_nxt = DONE;
      DONE:    if (OUT_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decode straight from state so reset drops them at once
  always_comb begin
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    case (state)
      IDLE:    IN_READY  = 1'b1;
      DONE:    OUT_VALID = 1'b1;
      default: begin
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
      end
    endcase
  end

  // Normalizer datapath and result registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sr   <= 15'd0;
      expo <= 4'd0;
      sign <= 1'b0;
      DL   <= 11'd0;
      DS   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            sr   <= dqm;
            expo <= 4'd14;
            sign <= D[15];
          end
        end
        NORM: begin
          if (norm_done) begin
            DL <= {expo, sr[13:7]};
            DS <= sign;
          end else begin
            sr   <= {sr[13:0], 1'b0};
            expo <= expo - 4'd1;
          end
        end
        default: begin
          sr <= sr;
        end
      endcase
    end
  end

endmodule
